lcd8080_master: RTL and testbench

Intel-8080-style parallel bus initiator driving an external LCD panel controller over an 8-bit interface. It takes command/data transactions from an upstream valid/ready request port, generates CSn/RS/WRn/RDn strobes with parameterised low/high widths, and returns read data on a one-cycle response pulse. It is the host-side counterpart of the panel-side 8080 receiver in the LCD path. The top level combines LCD_DOUT/LCD_DOE/LCD_DIN into the tristate pad.

---
 rtl/lcd8080_pkg.sv | 27 ++
 rtl/lcd8080_strobe_timer.sv | 24 ++
 rtl/lcd8080_master.sv | 145 ++++++++++++++
 tb/tb_lcd8080_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd8080_pkg.sv
// Shared types and constants for the 8080-style LCD bus initiator.
package lcd8080_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE_LO,
    ST_STROBE_HI
  } lcd_state_e;

  localparam int unsigned WR_LO_DEF = 2;
  localparam int unsigned WR_HI_DEF = 2;
  localparam int unsigned RD_LO_DEF = 8;
  localparam int unsigned RD_HI_DEF = 4;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [7:0] CMD_RDDID = 8'h04;
  localparam logic [7:0] CMD_RDDST = 8'h09;

  // Counter preload for a phase lasting w cycles.
  function automatic logic [3:0] width_load(input int unsigned w);
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/lcd8080_strobe_timer.sv
// Strobe phase timer: 4-bit load/decrement counter flagging the last phase cycle.
module lcd8080_strobe_timer (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/lcd8080_master.sv
// Intel-8080-style LCD bus initiator: valid/ready requests in, CSn/RS/WRn/RDn strobes out.
// Define LCD8080_READ_EN to build the read path; otherwise reads are acknowledged with 0x00.
module lcd8080_master
  import lcd8080_pkg::*;
#(
  parameter int unsigned WR_LO_CYC = WR_LO_DEF,
  parameter int unsigned WR_HI_CYC = WR_HI_DEF,
  parameter int unsigned RD_LO_CYC = RD_LO_DEF,
  parameter int unsigned RD_HI_CYC = RD_HI_DEF
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RS,
  input  logic       REQ_RD,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       LCD_CSn,
  output logic       LCD_RS,
  output logic       LCD_WRn,
  output logic       LCD_RDn,
  output logic [7:0] LCD_DOUT,
  output logic       LCD_DOE,
  input  logic [7:0] LCD_DIN
);

  lcd_state_e state_q, state_d;
  logic       rs_q, rd_q;
  logic [7:0] data_q;
  logic       t_load, t_last;
  logic [3:0] t_val;
  logic       accept, do_bus;
  logic       nxt_rs, nxt_rd;
  logic [7:0] nxt_data;

  lcd8080_strobe_timer u_timer (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (t_load),
    .load_val (t_val),
    .last     (t_last)
  );

  assign REQ_READY = (state_q == ST_IDLE) || ((state_q == ST_STROBE_HI) && t_last);
  assign BUSY      = (state_q != ST_IDLE);
  assign accept    = REQ_VALID && REQ_READY;

`ifdef LCD8080_READ_EN
  assign do_bus = accept;
`else
  assign do_bus = accept && !REQ_RD;
`endif

  // Outputs are registered from the next state, so they must see the request being latched.
  assign nxt_rs   = do_bus ? REQ_RS   : rs_q;
  assign nxt_rd   = do_bus ? REQ_RD   : rd_q;
  assign nxt_data = do_bus ? REQ_DATA : data_q;

  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (do_bus) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_STROBE_LO;
        t_load  = 1'b1;
        t_val   = rd_q ? width_load(RD_LO_CYC) : width_load(WR_LO_CYC);
      end
      ST_STROBE_LO: begin
        if (t_last) begin
          state_d = ST_STROBE_HI;
          t_load  = 1'b1;
          t_val   = rd_q ? width_load(RD_HI_CYC) : width_load(WR_HI_CYC);
        end
      end
      ST_STROBE_HI: begin
        if (t_last) state_d = do_bus ? ST_SETUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      rs_q     <= 1'b0;
      rd_q     <= 1'b0;
      data_q   <= '0;
      LCD_CSn  <= 1'b1;
      LCD_RS   <= 1'b0;
      LCD_WRn  <= 1'b1;
      LCD_DOE  <= 1'b0;
      LCD_DOUT <= '0;
    end else begin
      state_q <= state_d;
      if (do_bus) begin
        rs_q   <= REQ_RS;
        rd_q   <= REQ_RD;
        data_q <= REQ_DATA;
      end
      LCD_CSn <= (state_d == ST_IDLE);
      if (state_d != ST_IDLE) LCD_RS <= nxt_rs;
      LCD_WRn <= !((state_d == ST_STROBE_LO) && !nxt_rd);
      LCD_DOE <= (state_d != ST_IDLE) && !nxt_rd;
      if ((state_d != ST_IDLE) && !nxt_rd) LCD_DOUT <= nxt_data;
    end
  end

`ifdef LCD8080_READ_EN
  logic capture;

  assign capture = (state_q == ST_STROBE_LO) && t_last && rd_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      LCD_RDn   <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
    end else begin
      LCD_RDn   <= !((state_d == ST_STROBE_LO) && nxt_rd);
      RSP_VALID <= capture;
      if (capture) RSP_DATA <= LCD_DIN;
    end
  end
`else
  logic unused_din;

  assign unused_din = ^LCD_DIN;
  assign LCD_RDn    = 1'b1;
  assign RSP_DATA   = '0;

  // Reads are swallowed at accept so the upstream still sees a response.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) RSP_VALID <= 1'b0;
    else       RSP_VALID <= accept && REQ_RD;
  end
`endif

endmodule

// File: tb/tb_lcd8080_master.sv
// Self-checking bench for lcd8080_master: transaction-level frame model plus directed literal checks.
module tb_lcd8080_master;
  import lcd8080_pkg::*;

  localparam int unsigned WLO = 2;
  localparam int unsigned WHI = 2;
  localparam int unsigned RLO = 8;
  localparam int unsigned RHI = 4;

  logic       CLK, nRST;
  logic       REQ_VALID, REQ_READY, REQ_RS, REQ_RD;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BUSY, LCD_CSn, LCD_RS, LCD_WRn, LCD_RDn, LCD_DOE;
  logic [7:0] LCD_DOUT, LCD_DIN;

  int checks = 0;
  int errors = 0;

  lcd8080_master #(
    .WR_LO_CYC (WLO),
    .WR_HI_CYC (WHI),
    .RD_LO_CYC (RLO),
    .RD_HI_CYC (RHI)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_RS    (REQ_RS),
    .REQ_RD    (REQ_RD),
    .REQ_DATA  (REQ_DATA),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .BUSY      (BUSY),
    .LCD_CSn   (LCD_CSn),
    .LCD_RS    (LCD_RS),
    .LCD_WRn   (LCD_WRn),
    .LCD_RDn   (LCD_RDn),
    .LCD_DOUT  (LCD_DOUT),
    .LCD_DOE   (LCD_DOE),
    .LCD_DIN   (LCD_DIN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One expected bus cycle.
  typedef struct packed {
    logic       csn, wrn, rdn, doe, rs;
    logic [7:0] dout;
    logic       rspv, cap, busy;
  } frame_t;

  frame_t     q[$];
  logic [7:0] m_rsp;

  function automatic frame_t idle_f();
    frame_t f;
    f = '0;
    f.csn = 1'b1;
    f.wrn = 1'b1;
    f.rdn = 1'b1;
    return f;
  endfunction

  function automatic void push_txn(input logic rs, input logic rd, input logic [7:0] d);
    frame_t f;
    int unsigned lo, hi;
`ifndef LCD8080_READ_EN
    if (rd) begin
      f = idle_f();
      f.rspv = 1'b1;
      q.push_back(f);
      return;
    end
`endif
    lo = rd ? RLO : WLO;
    hi = rd ? RHI : WHI;
    f = idle_f();
    f.csn = 1'b0; f.rs = rs; f.doe = !rd; f.dout = d; f.busy = 1'b1;
    q.push_back(f);
    for (int unsigned i = 0; i < lo; i++) begin
      frame_t g;
      g = f;
      g.wrn = rd;
      g.rdn = !rd;
      g.cap = rd && (i == lo - 1);
      q.push_back(g);
    end
    for (int unsigned i = 0; i < hi; i++) begin
      frame_t g;
      g = f;
      g.rspv = rd && (i == 0);
      q.push_back(g);
    end
  endfunction

  // Model advance: one frame per clock; accept when at most the final frame remains.
  initial begin
    m_rsp = 8'h00;
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) begin
        q.delete();
        m_rsp = 8'h00;
      end else begin
        bit rdy;
        rdy = (q.size() <= 1);
        if (q.size() > 0) begin
          if (q[0].cap) m_rsp = LCD_DIN;
          void'(q.pop_front());
        end
        if (REQ_VALID && rdy) push_txn(REQ_RS, REQ_RD, REQ_DATA);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      frame_t e;
      @(negedge CLK);
      e = (q.size() > 0) ? q[0] : idle_f();
      chk("csn", LCD_CSn, e.csn);
      chk("wrn", LCD_WRn, e.wrn);
      chk("rdn", LCD_RDn, e.rdn);
      chk("doe", LCD_DOE, e.doe);
      if (!e.csn) chk("rs", LCD_RS, e.rs);
      if (e.doe) chk("dout", LCD_DOUT, e.dout);
      chk("rsp_valid", RSP_VALID, e.rspv);
      chk("rsp_data", RSP_DATA, m_rsp);
      chk("busy", BUSY, e.busy);
      chk("req_ready", REQ_READY, (q.size() <= 1));
    end
  end

  // Activity counters for directed checks.
  int cyc = 0, csn_low_cnt = 0, csn_fall_cnt = 0, rsp_cnt = 0, rdn_low_cnt = 0;
  int wr_cyc[$];
  logic prev_csn = 1'b1, prev_wrn = 1'b1;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (!LCD_CSn) csn_low_cnt++;
      if (!LCD_RDn) rdn_low_cnt++;
      if (prev_csn && !LCD_CSn) csn_fall_cnt++;
      if (prev_wrn && !LCD_WRn) wr_cyc.push_back(cyc);
      if (RSP_VALID) rsp_cnt++;
      prev_csn = LCD_CSn;
      prev_wrn = LCD_WRn;
    end
  end

  bit din_force = 1'b0;
  initial begin
    LCD_DIN = 8'h00;
    forever begin
      @(negedge CLK);
      LCD_DIN = din_force ? 8'hA5 : 8'($urandom);
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic send(input logic rs, input logic rd, input logic [7:0] d, input bit hold);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    REQ_VALID = 1'b1;
    REQ_RS = rs;
    REQ_RD = rd;
    REQ_DATA = d;
    while (!ok && n < 40) begin
      ok = REQ_READY;
      @(posedge CLK);
      @(negedge CLK);
      n++;
    end
    chk("accept", ok, 1);
    if (!hold) REQ_VALID = 1'b0;
  endtask

  initial begin
    logic [6:0] csn_tr, wrn_tr, doe_tr;
    logic [7:0] d0;
    int b_low, b_fall, b_rsp, b_rdn, n0, rsp_at;
    logic [7:0] rsp_val;
    bit doe_seen;

    nRST = 1'b1;
    REQ_VALID = 1'b0; REQ_RS = 1'b0; REQ_RD = 1'b0; REQ_DATA = 8'h00;
    #1 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_csn", LCD_CSn, 1);
    chk("rst_wrn", LCD_WRn, 1);
    chk("rst_rdn", LCD_RDn, 1);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_doe", LCD_DOE, 0);
    chk("rst_dout", LCD_DOUT, 8'h00);
    chk("rst_rspv", RSP_VALID, 0);
    chk("rst_rspd", RSP_DATA, 8'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", REQ_READY, 1);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single command write 0x2C.
    send(1'b0, 1'b0, CMD_RAMWR, 1'b0);
    d0 = LCD_DOUT;
    for (int i = 0; i < 7; i++) begin
      csn_tr[i] = LCD_CSn;
      wrn_tr[i] = LCD_WRn;
      doe_tr[i] = LCD_DOE;
      @(negedge CLK);
    end
    chk("wr_csn_trace", csn_tr, 7'b1100000);
    chk("wr_wrn_trace", wrn_tr, 7'b1111001);
    chk("wr_doe_trace", doe_tr, 7'b0011111);
    chk("wr_dout", d0, 8'h2C);

    // Four-byte data burst.
    b_low = csn_low_cnt; b_fall = csn_fall_cnt; n0 = wr_cyc.size();
    send(1'b1, 1'b0, 8'h11, 1'b1);
    send(1'b1, 1'b0, 8'h22, 1'b1);
    send(1'b1, 1'b0, 8'h33, 1'b1);
    send(1'b1, 1'b0, 8'h44, 1'b0);
    repeat (8) @(negedge CLK);
    chk("burst_csn_low", csn_low_cnt - b_low, 20);
    chk("burst_csn_fall", csn_fall_cnt - b_fall, 1);
    chk("burst_wr_pulses", wr_cyc.size() - n0, 4);
    if (wr_cyc.size() - n0 == 4) begin
      chk("burst_wr_gap", wr_cyc[n0 + 1] - wr_cyc[n0], 5);
      chk("burst_wr_span", wr_cyc[n0 + 3] - wr_cyc[n0], 15);
    end

    // Single data read.
    din_force = 1'b1;
    b_rsp = rsp_cnt; b_low = csn_low_cnt; b_rdn = rdn_low_cnt;
    rsp_at = 0; rsp_val = 8'hFF; doe_seen = 1'b0;
    send(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      if (RSP_VALID && rsp_at == 0) begin
        rsp_at = i;
        rsp_val = RSP_DATA;
      end
      doe_seen |= LCD_DOE;
      @(negedge CLK);
    end
    din_force = 1'b0;
    chk("rd_rsp_count", rsp_cnt - b_rsp, 1);
    chk("rd_doe_seen", doe_seen, 0);
`ifdef LCD8080_READ_EN
    chk("rd_rsp_cycle", rsp_at, 10);
    chk("rd_rsp_data", rsp_val, 8'hA5);
    chk("rd_rdn_low", rdn_low_cnt - b_rdn, 8);
`else
    chk("rd_rsp_cycle", rsp_at, 1);
    chk("rd_rsp_data", rsp_val, 8'h00);
    chk("rd_csn_low", csn_low_cnt - b_low, 0);
    chk("rd_rdn_low", rdn_low_cnt - b_rdn, 0);
`endif

`ifdef LCD8080_READ_EN
    // Write followed directly by a read.
    b_fall = csn_fall_cnt;
    send(1'b1, 1'b0, 8'h55, 1'b1);
    send(1'b1, 1'b1, 8'h00, 1'b0);
    chk("wr2rd_setup_doe", LCD_DOE, 0);
    chk("wr2rd_setup_csn", LCD_CSn, 0);
    chk("wr2rd_setup_rdn", LCD_RDn, 1);
    @(negedge CLK);
    chk("wr2rd_lo_rdn", LCD_RDn, 0);
    repeat (14) @(negedge CLK);
    chk("wr2rd_csn_fall", csn_fall_cnt - b_fall, 1);
`endif

    // Asynchronous reset during the write strobe.
    send(1'b0, 1'b0, CMD_CASET, 1'b0);
    @(posedge CLK);
    #2;
    chk("arst_pre_wrn", LCD_WRn, 0);
    nRST = 1'b0;
    #1;
    chk("arst_csn", LCD_CSn, 1);
    chk("arst_wrn", LCD_WRn, 1);
    chk("arst_rdn", LCD_RDn, 1);
    chk("arst_doe", LCD_DOE, 0);
    @(negedge CLK);
    nRST = 1'b1;
    b_rsp = rsp_cnt;
    repeat (2) @(negedge CLK);
    chk("arst_busy", BUSY, 0);
    repeat (10) @(negedge CLK);
    chk("arst_no_rsp", rsp_cnt - b_rsp, 0);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      bit hold;
      logic rd;
      hold = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      send(1'($urandom), rd, 8'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    REQ_VALID = 1'b0;
    repeat (20) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
